// File: rtl/compute_disparity.sv
// Winner-take-all disparity selection: pipelined min/second-min tree over the
// aggregated cost vector, followed by a registered uniqueness-ratio check.
module compute_disparity #(
   parameter int NUM_DISP   = 108,
   parameter int COST_W     = 8,
   parameter int DISP_W     = 7,
   parameter int DIM_W      = 10,
   parameter int UNIQ_RATIO = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [NUM_DISP*COST_W-1:0] cost_aggr,
   input  logic [DIM_W-1:0]           row,
   input  logic [DIM_W-1:0]           col,
   output logic [DISP_W-1:0]          disp,
   output logic [COST_W-1:0]          min_cost,
   output logic                       disp_ok,
   output logic [DIM_W-1:0]           out_row,
   output logic [DIM_W-1:0]           out_col,
   output logic                       valid
);

   localparam int LEVELS = $clog2(NUM_DISP);

   function automatic int unsigned nodes(input int unsigned l);
      int unsigned n;
      n = NUM_DISP;
      for (int unsigned k = 0; k < l; k++) n = (n + 1) / 2;
      return n;
   endfunction

   function automatic int unsigned base(input int unsigned l);
      int unsigned b;
      b = 0;
      for (int unsigned k = 0; k < l; k++) b += nodes(k);
      return b;
   endfunction

   // Flat node numbering: leaves first, then each tree level in turn; root last.
   localparam int unsigned TOTAL = base(LEVELS) + 1;
   localparam int unsigned NREG  = TOTAL - NUM_DISP;
   localparam int unsigned ROOT  = TOTAL - 1;

   typedef struct packed {
      logic [COST_W-1:0] best;
      logic [DISP_W-1:0] idx;
      logic [COST_W-1:0] second;
   } rec_t;

   function automatic rec_t merge(input rec_t a, input rec_t b);
      rec_t r;
      if (a.best <= b.best) begin
         r.best   = a.best;
         r.idx    = a.idx;
         r.second = b.best;
      end else begin
         r.best   = b.best;
         r.idx    = b.idx;
         r.second = a.best;
      end
      if (a.second < r.second) r.second = a.second;
      if (b.second < r.second) r.second = b.second;
      return r;
   endfunction

   rec_t              all_rec [TOTAL];
   rec_t              tree_q  [NREG];
   rec_t              root;
   logic [LEVELS-1:0] v_sh;
   logic [DIM_W-1:0]  row_sh  [LEVELS];
   logic [DIM_W-1:0]  col_sh  [LEVELS];
   logic [15:0]       lhs;
   logic [15:0]       rhs;
   logic              uniq_ok;

   always_comb begin
      for (int unsigned d = 0; d < NUM_DISP; d++) begin
         all_rec[d].best   = cost_aggr[d*COST_W +: COST_W];
         all_rec[d].idx    = DISP_W'(d);
         all_rec[d].second = '1;
      end
      for (int unsigned k = 0; k < NREG; k++) all_rec[NUM_DISP + k] = tree_q[k];
   end

   // An odd trailing node at a level is copied through unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < NREG; k++) tree_q[k] <= '0;
      end else begin
         for (int unsigned l = 1; l <= LEVELS; l++) begin
            for (int unsigned i = 0; i < nodes(l); i++) begin
               if (2*i + 1 < nodes(l - 1))
                  tree_q[base(l) - NUM_DISP + i] <= merge(all_rec[base(l - 1) + 2*i],
                                                          all_rec[base(l - 1) + 2*i + 1]);
               else
                  tree_q[base(l) - NUM_DISP + i] <= all_rec[base(l - 1) + 2*i];
            end
         end
      end
   end

   always_comb begin
      root    = all_rec[ROOT];
      lhs     = 16'(root.second) * 16'(100 - UNIQ_RATIO);
      rhs     = 16'(root.best) * 16'd100;
      uniq_ok = (NUM_DISP == 1) || (lhs >= rhs);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_sh     <= '0;
         for (int unsigned k = 0; k < LEVELS; k++) begin
            row_sh[k] <= '0;
            col_sh[k] <= '0;
         end
         valid    <= 1'b0;
         disp     <= '0;
         min_cost <= '0;
         disp_ok  <= 1'b0;
         out_row  <= '0;
         out_col  <= '0;
      end else begin
         v_sh[0]   <= en;
         row_sh[0] <= row;
         col_sh[0] <= col;
         for (int unsigned k = 1; k < LEVELS; k++) begin
            v_sh[k]   <= v_sh[k - 1];
            row_sh[k] <= row_sh[k - 1];
            col_sh[k] <= col_sh[k - 1];
         end
         valid <= v_sh[LEVELS - 1];
         // Data outputs only move on a valid pixel so they hold between strobes.
         if (v_sh[LEVELS - 1]) begin
            min_cost <= root.best;
            disp_ok  <= uniq_ok;
            disp     <= uniq_ok ? root.idx : '0;
            out_row  <= row_sh[LEVELS - 1];
            out_col  <= col_sh[LEVELS - 1];
         end
      end
   end

endmodule

// File: tb/tb_compute_disparity.sv
// Bench for compute_disparity: directed cases plus randomized traffic against
// a plain min / second-min reference model with latency tracking.
module tb_compute_disparity;

   localparam int ND  = 108;
   localparam int CW  = 8;
   localparam int DW  = 7;
   localparam int TW  = 10;
   localparam int UR  = 10;
   localparam int LAT = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [ND*CW-1:0] cost_aggr;
   logic [TW-1:0]    row;
   logic [TW-1:0]    col;
   logic [DW-1:0]    disp;
   logic [CW-1:0]    min_cost;
   logic             disp_ok;
   logic [TW-1:0]    out_row;
   logic [TW-1:0]    out_col;
   logic             valid;

   always #5 clk = ~clk;

   compute_disparity #(
      .NUM_DISP  (ND),
      .COST_W    (CW),
      .DISP_W    (DW),
      .DIM_W     (TW),
      .UNIQ_RATIO(UR)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .cost_aggr(cost_aggr),
      .row      (row),
      .col      (col),
      .disp     (disp),
      .min_cost (min_cost),
      .disp_ok  (disp_ok),
      .out_row  (out_row),
      .out_col  (out_col),
      .valid    (valid)
   );

   typedef struct {
      int stamp;
      int disp;
      int cost;
      int ok;
      int row;
      int col;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      assert (got === want)
      else begin
         n_err++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   function automatic exp_t model(input logic [ND*CW-1:0] v, input int r, input int c);
      exp_t e;
      int   cs[ND];
      int   best, idx, second;
      best   = 256;
      idx    = 0;
      second = 256;
      for (int d = 0; d < ND; d++) begin
         cs[d] = int'(v[d*CW +: CW]);
         if (cs[d] < best) begin
            best = cs[d];
            idx  = d;
         end
      end
      for (int d = 0; d < ND; d++)
         if (d != idx && cs[d] < second) second = cs[d];
      e.stamp = 0;
      e.ok    = (second * (100 - UR) >= best * 100) ? 1 : 0;
      e.disp  = e.ok ? idx : 0;
      e.cost  = best;
      e.row   = r;
      e.col   = c;
      return e;
   endfunction

   function automatic logic [ND*CW-1:0] fill(input int val);
      logic [ND*CW-1:0] v;
      for (int d = 0; d < ND; d++) v[d*CW +: CW] = CW'(val);
      return v;
   endfunction

   task automatic observe();
      exp_t e;
      if (valid) begin
         if (q.size() == 0) begin
            chk("spurious_valid", 32'(valid), 0);
         end else begin
            e = q.pop_front();
            chk("latency",  32'(cyc - e.stamp), LAT);
            chk("disp",     32'(disp),     32'(e.disp));
            chk("min_cost", 32'(min_cost), 32'(e.cost));
            chk("disp_ok",  32'(disp_ok),  32'(e.ok));
            chk("out_row",  32'(out_row),  32'(e.row));
            chk("out_col",  32'(out_col),  32'(e.col));
         end
      end else if (q.size() > 0 && cyc - q[0].stamp >= LAT) begin
         chk("missing_valid", 32'(valid), 1);
         void'(q.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      observe();
   endtask

   task automatic send(input logic [ND*CW-1:0] v, input int r, input int c);
      exp_t e;
      en        = 1'b1;
      cost_aggr = v;
      row       = TW'(r);
      col       = TW'(c);
      e         = model(v, r, c);
      e.stamp   = cyc;
      q.push_back(e);
      tick();
   endtask

   task automatic idle();
      en = 1'b0;
      tick();
   endtask

   task automatic drain();
      for (int k = 0; k < 3 * LAT && q.size() > 0; k++) idle();
      chk("drain", 32'(q.size()), 0);
   endtask

   logic [ND*CW-1:0] v;

   initial begin
      rst       = 1'b0;
      en        = 1'b0;
      cost_aggr = '0;
      row       = '0;
      col       = '0;
      #12;
      chk("rst_valid",    32'(valid),    0);
      chk("rst_disp",     32'(disp),     0);
      chk("rst_min_cost", 32'(min_cost), 0);
      chk("rst_out_row",  32'(out_row),  0);
      rst = 1'b1;
      idle();
      idle();

      // Single minimum
      v = fill(200); v[37*CW +: CW] = 8'd20;
      send(v, 5, 9);
      // Tie-break between equal minima
      v = fill(255); v[12*CW +: CW] = 8'd50; v[80*CW +: CW] = 8'd50;
      send(v, 1, 2);
      // Uniqueness boundary pass then fail
      v = fill(255); v[3*CW +: CW] = 8'd90; v[60*CW +: CW] = 8'd100;
      send(v, 3, 4);
      v[60*CW +: CW] = 8'd99;
      send(v, 6, 7);
      // Edge indices
      v = fill(255); v[0*CW +: CW] = 8'd1;
      send(v, 10, 11);
      v = fill(255); v[107*CW +: CW] = 8'd1;
      send(v, 1023, 1023);
      // Equal costs and zero-cost winners
      send(fill(77), 20, 21);
      v = fill(0); for (int d = 0; d < 10; d++) v[d*CW +: CW] = 8'd200;
      send(v, 30, 31);
      idle();
      drain();

      for (int i = 0; i < 300; i++) begin
         int mode;
         while ($urandom_range(0, 99) < 35) idle();
         mode = int'($urandom_range(0, 3));
         if (mode == 0) begin
            for (int d = 0; d < ND; d++) v[d*CW +: CW] = CW'($urandom);
         end else if (mode == 3) begin
            v = fill(int'($urandom_range(0, 255)));
         end else begin
            for (int d = 0; d < ND; d++) v[d*CW +: CW] = CW'($urandom_range(100, 255));
            v[$urandom_range(0, ND-1)*CW +: CW] = CW'($urandom_range(0, 120));
            if (mode == 2) v[$urandom_range(0, ND-1)*CW +: CW] = CW'($urandom_range(0, 130));
         end
         send(v, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      end
      idle();
      drain();

      // Reset mid-stream: four pixels in flight are discarded
      for (int i = 0; i < 4; i++) begin
         v = fill(180); v[(i + 40)*CW +: CW] = 8'd9;
         send(v, 100 + i, 200 + i);
      end
      en  = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_valid",    32'(valid),    0);
      chk("mid_rst_disp",     32'(disp),     0);
      chk("mid_rst_min_cost", 32'(min_cost), 0);
      chk("mid_rst_disp_ok",  32'(disp_ok),  0);
      chk("mid_rst_out_row",  32'(out_row),  0);
      chk("mid_rst_out_col",  32'(out_col),  0);
      q.delete();
      tick();
      rst = 1'b1;
      for (int k = 0; k < 2 * LAT; k++) idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
